// File: rtl/ex_pushpop_seq.sv
// ============================================================================
// Module   : ex_pushpop_seq
// Purpose  : Multi-register PUSH/POP burst sequencer for the EX1/EX2 memory
//            path; issues one slot access per mask bit and steps SP.
// Options  : EXPP_SPCHK_EN enables the PUSH stack-limit fault check.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_pushpop_seq #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 32,
  parameter int NREG    = 8,
  parameter int REGID_W = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               reqValid,
  input  logic               reqPop,
  input  logic [NREG-1:0]    reqMask,
  input  logic [REGID_W-1:0] reqBaseId,
  input  logic [ADDR_W-1:0]  regInSp,
  output logic [ADDR_W-1:0]  regOutSp,
  output logic               spWr,
  output logic [REGID_W-1:0] regRdId,
  input  logic [DATA_W-1:0]  regRdVal,
  output logic [REGID_W-1:0] regWrId,
  output logic [DATA_W-1:0]  regWrVal,
  output logic               regWrEn,
  output logic [ADDR_W-1:0]  memAddr,
  output logic [4:0]         memOpm,
  output logic [DATA_W-1:0]  memDataOut,
  input  logic [DATA_W-1:0]  memDataIn,
  input  logic               memOK,
  input  logic [ADDR_W-1:0]  regStkLim,
  output logic               exHold,
  output logic               busy,
  output logic               done,
  output logic               fault
);

  localparam int              IDX_W          = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [ADDR_W-1:0] STRIDE       = ADDR_W'(DATA_W / 8);
  localparam logic [4:0]      UMEM_OPM_READY = 5'd0;
  localparam logic [4:0]      UMEM_OPM_RD_Q  = 5'd1;
  localparam logic [4:0]      UMEM_OPM_WR_Q  = 5'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [NREG-1:0]      r_mask;
  logic                 r_pop;
  logic [REGID_W-1:0]   r_base;
  logic [ADDR_W-1:0]    r_ptr;
  logic                 r_skip;
  logic                 r_fault;

  logic                 w_accept;
  logic                 w_take;
  logic                 w_acc_skip;
  logic                 w_acc_fault;
  logic                 w_lim_fail;
  logic [IDX_W-1:0]     w_hi_idx;
  logic [IDX_W-1:0]     w_lo_idx;
  logic [IDX_W-1:0]     w_sel_idx;
  logic [NREG-1:0]      w_sel_bit;
  logic [NREG-1:0]      w_mask_rem;
  logic [REGID_W-1:0]   w_sel_id;
  logic [ADDR_W-1:0]    w_ptr_dec;
  logic [ADDR_W-1:0]    w_ptr_inc;

  // PUSH drains from the top of the mask, POP from the bottom, so a POP
  // burst restores exactly the layout the matching PUSH burst produced.
  always_comb begin
    w_hi_idx = '0;
    w_lo_idx = '0;
    for (int i = 0; i < NREG; i++) begin
      if (r_mask[i]) w_hi_idx = IDX_W'(i);
    end
    for (int i = NREG - 1; i >= 0; i--) begin
      if (r_mask[i]) w_lo_idx = IDX_W'(i);
    end
  end

  assign w_sel_idx  = r_pop ? w_lo_idx : w_hi_idx;
  assign w_sel_bit  = NREG'(1) << w_sel_idx;
  assign w_mask_rem = r_mask & ~w_sel_bit;
  assign w_sel_id   = r_base + REGID_W'(w_sel_idx);
  assign w_ptr_dec  = r_ptr - STRIDE;
  assign w_ptr_inc  = r_ptr + STRIDE;

`ifdef EXPP_SPCHK_EN
  localparam int CHK_W = ADDR_W + 16;
  logic [CHK_W-1:0] w_need;

  // Compared as sp < need + limit in a wide field so no term can wrap.
  always_comb begin
    w_need = '0;
    for (int i = 0; i < NREG; i++) begin
      w_need = w_need + CHK_W'(reqMask[i]);
    end
    w_need     = w_need * CHK_W'(DATA_W / 8);
    w_lim_fail = (CHK_W'(regInSp) < (w_need + CHK_W'(regStkLim)));
  end
`else
  logic unused_stk_lim;
  assign unused_stk_lim = ^regStkLim;
  assign w_lim_fail     = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_take      = 1'b0;
    w_acc_skip  = 1'b0;
    w_acc_fault = 1'b0;
    exHold      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    fault       = 1'b0;
    spWr        = 1'b0;
    regOutSp    = '0;
    regRdId     = '0;
    regWrId     = '0;
    regWrVal    = '0;
    regWrEn     = 1'b0;
    memAddr     = '0;
    memOpm      = UMEM_OPM_READY;
    memDataOut  = '0;
    case (r_state)
      ST_IDLE: begin
        if (reqValid) begin
          w_accept = 1'b1;
          exHold   = 1'b1;
          if (reqMask == '0) begin
            w_acc_skip  = 1'b1;
            w_state_nxt = ST_FINISH;
          end else if (!reqPop && w_lim_fail) begin
            w_acc_skip  = 1'b1;
            w_acc_fault = 1'b1;
            w_state_nxt = ST_FINISH;
          end else begin
            w_state_nxt = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        busy   = 1'b1;
        exHold = 1'b1;
        if (r_pop) begin
          memAddr = r_ptr;
          memOpm  = UMEM_OPM_RD_Q;
          if (memOK) begin
            regWrEn  = 1'b1;
            regWrId  = w_sel_id;
            regWrVal = memDataIn;
          end
        end else begin
          memAddr    = w_ptr_dec;
          memOpm     = UMEM_OPM_WR_Q;
          regRdId    = w_sel_id;
          memDataOut = regRdVal;
        end
        if (memOK) begin
          w_take = 1'b1;
          if (w_mask_rem == '0) w_state_nxt = ST_FINISH;
        end
      end
      ST_FINISH: begin
        busy        = 1'b1;
        done        = 1'b1;
        fault       = r_fault;
        spWr        = ~r_skip;
        regOutSp    = r_skip ? '0 : r_ptr;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mask  <= '0;
      r_pop   <= 1'b0;
      r_base  <= '0;
      r_ptr   <= '0;
      r_skip  <= 1'b0;
      r_fault <= 1'b0;
    end else if (w_accept) begin
      r_mask  <= reqMask;
      r_pop   <= reqPop;
      r_base  <= reqBaseId;
      r_ptr   <= regInSp;
      r_skip  <= w_acc_skip;
      r_fault <= w_acc_fault;
    end else if (w_take) begin
      r_mask <= w_mask_rem;
      r_ptr  <= r_pop ? w_ptr_inc : w_ptr_dec;
    end
  end

endmodule

`default_nettype wire
